// File: rtl/riscv_pkg.sv
// Shared decode constants, field positions and the fetch FSM state type.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_S   = 7'b0100011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   // instruction field bit positions
   localparam int OPC_LO = 0;
   localparam int OPC_HI = 6;
   localparam int F3_LO  = 12;
   localparam int F3_HI  = 14;
   localparam int F7_LO  = 25;
   localparam int F7_HI  = 31;

   typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} fetch_state_t;

   function automatic logic [6:0] opcode_of(input logic [31:0] i);
      return i[OPC_HI:OPC_LO];
   endfunction

   function automatic logic [2:0] funct3_of(input logic [31:0] i);
      return i[F3_HI:F3_LO];
   endfunction

   function automatic logic [6:0] funct7_of(input logic [31:0] i);
      return i[F7_HI:F7_LO];
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register plus a one-entry skid buffer.
// Priority: flush > pop (skid -> IF/ID) > load (memory -> IF/ID) > hold > bubble.
// push captures the response into the skid while IF/ID is held by stall.
module if_id_reg
   import riscv_pkg::*;
#(
   parameter int          XLEN    = 32,
   parameter logic [31:0] NOP_VAL = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            load,
   input  logic            push,
   input  logic            pop,
   input  logic            hold,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            id_valid,
   output logic [31:0]     id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [6:0]      id_opcode,
   output logic [2:0]      id_funct3,
   output logic [6:0]      id_funct7
);

   logic            v_q, skv_q;
   logic [31:0]     ins_q, skins_q;
   logic [XLEN-1:0] pc_q, skpc_q;

   // IF/ID and skid state update
   always_ff @(posedge clk) begin
      if (reset) begin
         v_q     <= 1'b0;
         ins_q   <= NOP_VAL;
         pc_q    <= '0;
         skv_q   <= 1'b0;
         skins_q <= NOP_VAL;
         skpc_q  <= '0;
      end else if (flush) begin
         v_q   <= 1'b0;
         skv_q <= 1'b0;
      end else begin
         if (pop && skv_q) begin
            v_q   <= 1'b1;
            ins_q <= skins_q;
            pc_q  <= skpc_q;
            skv_q <= 1'b0;
         end else if (load) begin
            v_q   <= 1'b1;
            ins_q <= in_instr;
            pc_q  <= in_pc;
         end else if (!hold) begin
            v_q <= 1'b0;
         end
         if (push) begin
            skv_q   <= 1'b1;
            skins_q <= in_instr;
            skpc_q  <= in_pc;
         end
      end
   end

   assign id_valid  = v_q;
   assign id_instr  = v_q ? ins_q : NOP_VAL;
   assign id_pc     = pc_q;
   assign id_opcode = opcode_of(id_instr);
   assign id_funct3 = funct3_of(id_instr);
   assign id_funct7 = funct7_of(id_instr);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the imem request FSM
// (FETCH/WAIT/HOLD/DRAIN) and feeds the IF/ID register.
// Optional: define FETCH_MISALIGN_CHECK_EN to flag misaligned redirect targets.
module fetch_stage #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            imem_valid,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   output logic [31:0]     id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [6:0]      id_opcode,
   output logic [2:0]      id_funct3,
   output logic [6:0]      id_funct7,
   output logic            misalign_err
);
   import riscv_pkg::*;

   fetch_state_t    state_q, state_nxt;
   logic [XLEN-1:0] pc_q, pc_nxt;
   logic            ld, psh, pp, fl;

   // state and PC registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_nxt;
         pc_q    <= pc_nxt;
      end
   end

   // next state, next PC and IF/ID controls; redirect overrides everything
   always_comb begin
      state_nxt = state_q;
      pc_nxt    = pc_q;
      ld        = 1'b0;
      psh       = 1'b0;
      pp        = 1'b0;
      fl        = 1'b0;
      case (state_q)
         FETCH: state_nxt = WAIT;
         WAIT: begin
            if (imem_valid) begin
               pc_nxt = pc_q + XLEN'(4);
               if (stall) begin
                  psh       = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  ld        = 1'b1;
                  state_nxt = FETCH;
               end
            end
         end
         HOLD: begin
            if (!stall) begin
               pp        = 1'b1;
               state_nxt = FETCH;
            end
         end
         DRAIN: begin
            if (imem_valid) state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
      if (redirect) begin
         pc_nxt = redirect_pc & ~XLEN'(3);
         fl     = 1'b1;
         ld     = 1'b0;
         psh    = 1'b0;
         pp     = 1'b0;
         // a request still in flight must have its response swallowed
         if ((state_q == WAIT || state_q == DRAIN) && !imem_valid) state_nxt = DRAIN;
         else                                                      state_nxt = FETCH;
      end
   end

   assign imem_req  = !reset && (state_q == FETCH || state_q == WAIT);
   assign imem_addr = pc_q;

   if_id_reg #(.XLEN(XLEN), .NOP_VAL(NOP_INSTR)) u_ifid (
      .clk      (clk),
      .reset    (reset),
      .flush    (fl),
      .load     (ld),
      .push     (psh),
      .pop      (pp),
      .hold     (stall),
      .in_instr (imem_rdata),
      .in_pc    (pc_q),
      .id_valid (id_valid),
      .id_instr (id_instr),
      .id_pc    (id_pc),
      .id_opcode(id_opcode),
      .id_funct3(id_funct3),
      .id_funct7(id_funct7)
   );

`ifdef FETCH_MISALIGN_CHECK_EN
   logic mis_q;
   // one-cycle flag for a redirect whose target is not word aligned
   always_ff @(posedge clk) begin
      if (reset) mis_q <= 1'b0;
      else       mis_q <= redirect && (redirect_pc[1:0] != 2'b00);
   end
   assign misalign_err = mis_q;
`else
   assign misalign_err = 1'b0;
`endif

endmodule
